// File: rtl/pipeline_reg_chain.sv
// Parametrised valid/ready register chain with bubble collapsing and synchronous flush.
// Each stage holds one WIDTH-bit word plus a valid bit. An empty stage always accepts
// from the stage before it, so a stalled chain compacts toward the output.
module pipeline_reg_chain #(
    parameter int               WIDTH     = 64,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             valid_reg [DEPTH];
    logic [WIDTH-1:0] data_reg  [DEPTH];

    // rdy[i]: stage i may load this cycle; rdy[DEPTH] is the downstream acceptance.
    logic [DEPTH:0]   rdy;
    logic             up_v      [DEPTH];
    logic [WIDTH-1:0] up_data   [DEPTH];

    // Ready ripples back from the output: a stage is ready if empty or if it drains.
    always_comb begin
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !valid_reg[i] | rdy[i + 1];
        end
    end

    // Input side is closed during flush and while reset is held.
    assign in_ready  = rdy[0] & !flush & reset;
    assign out_valid = valid_reg[DEPTH-1] & !flush;
    assign out_data  = data_reg[DEPTH-1];

    // Occupancy counts valid stages and deliberately ignores flush.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(valid_reg[i]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign up_v[gi]    = in_valid & in_ready;
                assign up_data[gi] = in_data;
            end else begin : g_body
                assign up_v[gi]    = valid_reg[gi-1];
                assign up_data[gi] = data_reg[gi-1];
            end

            // Stage register: flush clears valid only; data loads only on a real transfer.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_reg[gi] <= 1'b0;
                    data_reg[gi]  <= RESET_VAL;
                end else if (flush) begin
                    valid_reg[gi] <= 1'b0;
                end else if (rdy[gi]) begin
                    valid_reg[gi] <= up_v[gi];
                    if (up_v[gi]) begin
                        data_reg[gi] <= up_data[gi];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipeline_reg_chain.sv
// Directed bench for pipeline_reg_chain: a DEPTH=3 instance for streaming, back-pressure,
// bubble collapse, flush and asynchronous reset, plus a DEPTH=1 instance.
module tb_pipeline_reg_chain;

    logic       clk = 1'b0;
    logic       reset;
    int         vectors = 0;
    int         miscompares = 0;

    // DEPTH=3 instance signals
    logic       flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [1:0] occupancy;

    // DEPTH=1 instance signals
    logic       flush1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [7:0] in_data1, out_data1;
    logic       occupancy1;

    always #5 clk = ~clk;

    pipeline_reg_chain #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h5A)) dut3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipeline_reg_chain #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut1 (
        .clk(clk), .reset(reset), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .occupancy(occupancy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        flush1 = 1'b0; in_valid1 = 1'b0; in_data1 = 8'h00; out_ready1 = 1'b1;
        tick(); tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        vectors++; if (out_data !== 8'h5A) begin miscompares++; $display("FAIL reset_out_data: got %h expected 5a", out_data); end
        vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
        reset = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready: got %0b expected 1", in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        logic       exp_ov  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] exp_od  [6] = '{8'h5A, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h33};
        logic [1:0] exp_occ [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
        logic [7:0] pushes  [3] = '{8'h11, 8'h22, 8'h33};
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 3) begin
                in_valid = 1'b1; in_data = pushes[k];
                #1;
                vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready[%0d]: got %0b expected 1", k, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            tick();
            vectors++; if (out_valid !== exp_ov[k]) begin miscompares++; $display("FAIL stream_out_valid[%0d]: got %0b expected %0b", k, out_valid, exp_ov[k]); end
            vectors++; if (out_data !== exp_od[k]) begin miscompares++; $display("FAIL stream_out_data[%0d]: got %h expected %h", k, out_data, exp_od[k]); end
            vectors++; if (occupancy !== exp_occ[k]) begin miscompares++; $display("FAIL stream_occupancy[%0d]: got %0d expected %0d", k, occupancy, exp_occ[k]); end
            $display("stream cycle %0d: out_valid=%0b out_data=%h occ=%0d", k, out_valid, out_data, occupancy);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] pushes [3] = '{8'hA1, 8'hA2, 8'hA3};
        logic [7:0] drain  [3] = '{8'hA2, 8'hA3, 8'hA4};
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = pushes[k];
            #1;
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_fill_in_ready[%0d]: got %0b expected 1", k, in_ready); end
            tick();
        end
        in_data = 8'hA4;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full_in_ready: got %0b expected 0", in_ready); end
        vectors++; if (occupancy !== 2'd3) begin miscompares++; $display("FAIL bp_full_occupancy: got %0d expected 3", occupancy); end
        tick();
        vectors++; if (out_data !== 8'hA1 || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_stall_out: got %0b/%h expected 1/a1", out_valid, out_data); end
        vectors++; if (occupancy !== 2'd3) begin miscompares++; $display("FAIL bp_stall_occupancy: got %0d expected 3", occupancy); end
        out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_in_ready: got %0b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vectors++; if (out_valid !== 1'b1 || out_data !== drain[k]) begin miscompares++; $display("FAIL bp_drain[%0d]: got %0b/%h expected 1/%h", k, out_valid, out_data, drain[k]); end
            $display("bp drain %0d: out_data=%h occ=%0d", k, out_data, occupancy);
            tick();
        end
        vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin miscompares++; $display("FAIL bp_empty: got %0b/%0d expected 0/0", out_valid, occupancy); end
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h55;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        vectors++; if (occupancy !== 2'd1 || out_valid !== 1'b1 || out_data !== 8'h55) begin miscompares++; $display("FAIL bubble_setup: got occ=%0d ov=%0b od=%h expected 1/1/55", occupancy, out_valid, out_data); end
        in_valid = 1'b1; in_data = 8'h66;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bubble_in_ready0: got %0b expected 1", in_ready); end
        tick();
        in_data = 8'h77;
        #1;
        vectors++; if (in_ready !== 1'b1 || occupancy !== 2'd2) begin miscompares++; $display("FAIL bubble_in_ready1: got %0b/%0d expected 1/2", in_ready, occupancy); end
        tick();
        in_valid = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b0 || occupancy !== 2'd3) begin miscompares++; $display("FAIL bubble_full: got %0b/%0d expected 0/3", in_ready, occupancy); end
        out_ready = 1'b1;
        tick();
        vectors++; if (out_data !== 8'h66) begin miscompares++; $display("FAIL bubble_order_66: got %h expected 66", out_data); end
        tick();
        vectors++; if (out_data !== 8'h77) begin miscompares++; $display("FAIL bubble_order_77: got %h expected 77", out_data); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bubble_empty: got %0b expected 0", out_valid); end
        $display("test_bubble done");
    endtask

    task automatic test_flush();
        logic [7:0] pushes [3] = '{8'h01, 8'h02, 8'h03};
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = pushes[k];
            tick();
        end
        flush = 1'b1; in_data = 8'h04; out_ready = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid: got %0b expected 0", out_valid); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready: got %0b expected 0", in_ready); end
        vectors++; if (occupancy !== 2'd3) begin miscompares++; $display("FAIL flush_occupancy_unmasked: got %0d expected 3", occupancy); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        vectors++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL post_flush: got %0d/%0b expected 0/0", occupancy, out_valid); end
        tick(); tick(); tick();
        vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin miscompares++; $display("FAIL flush_no_capture: got %0b/%0d expected 0/0", out_valid, occupancy); end
        vectors++; if (out_data !== 8'h01) begin miscompares++; $display("FAIL flush_data_hold: got %h expected 01", out_data); end
        $display("test_flush done");
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hB1; tick();
        in_data = 8'hB2; tick();
        in_valid = 1'b0; tick();
        vectors++; if (occupancy !== 2'd2 || out_valid !== 1'b1 || out_data !== 8'hB1) begin miscompares++; $display("FAIL areset_setup: got %0d/%0b/%h expected 2/1/b1", occupancy, out_valid, out_data); end
        #2;
        reset = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_out_valid: got %0b expected 0", out_valid); end
        vectors++; if (out_data !== 8'h5A) begin miscompares++; $display("FAIL areset_out_data: got %h expected 5a", out_data); end
        vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("FAIL areset_occupancy: got %0d expected 0", occupancy); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL areset_in_ready: got %0b expected 0", in_ready); end
        tick();
        reset = 1'b1; out_ready = 1'b1;
        tick();
        vectors++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_release: got %0d/%0b expected 0/0", occupancy, out_valid); end
        $display("test_async_reset done");
    endtask

    task automatic test_depth1();
        logic       drv_or [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       drv_iv [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] drv_d  [6] = '{8'hC1, 8'hC2, 8'hC3, 8'hC3, 8'h00, 8'h00};
        logic       exp_ir [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       exp_ov [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] exp_od [6] = '{8'h00, 8'hC1, 8'hC2, 8'hC2, 8'hC3, 8'hC3};
        for (int c = 0; c < 6; c++) begin
            out_ready1 = drv_or[c]; in_valid1 = drv_iv[c]; in_data1 = drv_d[c];
            #1;
            vectors++; if (in_ready1 !== exp_ir[c]) begin miscompares++; $display("FAIL d1_in_ready[%0d]: got %0b expected %0b", c, in_ready1, exp_ir[c]); end
            vectors++; if (out_valid1 !== exp_ov[c]) begin miscompares++; $display("FAIL d1_out_valid[%0d]: got %0b expected %0b", c, out_valid1, exp_ov[c]); end
            vectors++; if (out_data1 !== exp_od[c]) begin miscompares++; $display("FAIL d1_out_data[%0d]: got %h expected %h", c, out_data1, exp_od[c]); end
            vectors++; if (occupancy1 !== exp_ov[c]) begin miscompares++; $display("FAIL d1_occupancy[%0d]: got %0b expected %0b", c, occupancy1, exp_ov[c]); end
            $display("depth1 cycle %0d: in_ready=%0b out_valid=%0b out_data=%h", c, in_ready1, out_valid1, out_data1);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_async_reset();
        test_depth1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
